// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction fetch stage.
//   - fetch_entry_t : one prefetch FIFO entry {pc, word}
//   - fetch_state_t : request-tracking FSM states
//   - bit positions of the pre-sliced decode fields
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    // IDLE: nothing in flight; WAIT: response will be kept;
    // DROP: response will be discarded (a redirect overtook it).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam int OP_LSB    = 26;
    localparam int OP_W      = 2;
    localparam int FUNCT_LSB = 20;
    localparam int FUNCT_W   = 6;
    localparam int RD_LSB    = 12;
    localparam int RD_W      = 4;
    localparam int BIT_7     = 7;
    localparam int BIT_4     = 4;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO of fetch_entry_t used as the prefetch buffer.
//   DEPTH must be a power of two (pointers wrap naturally).
//
// Ports
//   clk        in   clock
//   reset      in   asynchronous active-low reset
//   flush      in   empty the FIFO (wins over push/pop)
//   push       in   write push_data (ignored when full)
//   push_data  in   entry to write
//   pop        in   drop head entry (ignored when empty)
//   head       out  current head entry (undefined when count == 0)
//   count      out  number of valid entries
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full  & ~flush;
    assign do_pop  = pop  & ~empty & ~flush;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only ever
    // observed after it has been written, as tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage ahead of the control unit. Owns the program counter, issues
//   word fetches with at most one request in flight, buffers returned words in
//   a prefetch FIFO and presents them (with PC and decode slices) to the
//   decoder through a valid/ready handshake. A redirect flushes everything.
//
// Optional build macro
//   FETCH_BYPASS_EN : a response arriving while the FIFO is empty is shown on
//                     the instr outputs in the same cycle (0-cycle latency);
//                     consumed directly if instr_ready, otherwise buffered.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   imem_req/addr       fetch request and word-aligned address
//   imem_ready          request accepted when imem_req & imem_ready
//   imem_rvalid/rdata   one response per accepted request
//   redirect_valid/pc   PC redirect (branch taken / PC written)
//   instr_valid/ready   decoder handshake on the FIFO head
//   instr, instr_pc     head word and its address (0 when not valid)
//   op, funct, rd,      decode slices of instr
//   instr_7, instr_4
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [1:0]  op,
    output logic [5:0]  funct,
    output logic [3:0]  rd,
    output logic        instr_7,
    output logic        instr_4
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;      // address of the request currently in flight
    logic          run;         // low until the first edge after reset release
    logic [CW-1:0] count;
    logic          fifo_empty;
    logic          fifo_full;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          accept;
    logic          resp_keep;
    logic          bypass_hit;
    logic          push;
    logic          pop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));

    // Issue only from IDLE with buffer space; a redirect cycle never issues
    // because fetch_pc is about to change underneath the request.
    assign imem_req  = run && (state == IDLE) && !fifo_full && !redirect_valid;
    assign imem_addr = fetch_pc;
    assign accept    = imem_req & imem_ready;

    // Responses in IDLE (e.g. stragglers from before a reset) are ignored.
    assign resp_keep = (state == WAIT) && imem_rvalid && !redirect_valid;

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = resp_keep && fifo_empty;
`else
    assign bypass_hit = 1'b0;
`endif

    // A bypassed word that the decoder takes immediately never enters the FIFO.
    assign push = resp_keep && !(bypass_hit && instr_ready);
    assign pop  = !fifo_empty && instr_ready && !redirect_valid;

    assign push_entry = '{pc: req_pc, word: imem_rdata};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            run      <= 1'b0;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state <= state_next;
            run   <= 1'b1;
            if (redirect_valid)  fetch_pc <= align_word(redirect_pc);
            else if (accept)     fetch_pc <= fetch_pc + PC_STEP;
            if (accept)          req_pc   <= fetch_pc;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = WAIT;
            // A response in the redirect cycle itself is simply discarded;
            // only a still-outstanding response has to be dropped later.
            WAIT: begin
                if (imem_rvalid)         state_next = IDLE;
                else if (redirect_valid) state_next = DROP;
            end
            DROP: if (imem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        instr_valid = !fifo_empty || bypass_hit;
        instr       = '0;
        instr_pc    = '0;
        if (!fifo_empty) begin
            instr    = head.word;
            instr_pc = head.pc;
        end else if (bypass_hit) begin
            instr    = imem_rdata;
            instr_pc = req_pc;
        end
    end

    assign op      = instr[OP_LSB +: OP_W];
    assign funct   = instr[FUNCT_LSB +: FUNCT_W];
    assign rd      = instr[RD_LSB +: RD_W];
    assign instr_7 = instr[BIT_7];
    assign instr_4 = instr[BIT_4];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Self-checking bench for instr_fetch_unit. A memory model answers accepted
//   requests after mem_lat cycles; every kept response is pushed to a
//   scoreboard and compared when the decoder side consumes it.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
`ifdef FETCH_BYPASS_EN
    localparam int          LAT      = 0;
`else
    localparam int          LAT      = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        instr_7;
    logic        instr_4;

    instr_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .op             (op),
        .funct          (funct),
        .rd             (rd),
        .instr_7        (instr_7),
        .instr_4        (instr_4)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    fetch_entry_t sb[$];
    logic [31:0]  acc_log[$];
    logic [31:0]  pop_log[$];

    bit          pend = 0;
    bit          pend_drop = 0;
    logic [31:0] pend_pc = '0;
    int          pend_wait = 0;
    int          mem_lat = 1;
    logic [31:0] exp_pc = RESET_PC;
    bit          lat_armed = 0;
    logic [31:0] lat_pc = '0;
    int          lat_due = 0;

    bit          tb_redirect = 0;
    logic [31:0] tb_redirect_pc = '0;
    bit          tb_ready = 1;
    bit          tb_mem_ready = 1;
    bit          late_rvalid = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C96_A5F0;
    endfunction

    // One clock cycle: drive inputs after the edge, sample on the falling edge.
    task automatic cycle();
        bit           give;
        fetch_entry_t e;
        @(posedge clk);
        #1;
        cyc++;
        give = 0;
        if (pend) begin
            if (pend_wait <= 1) give = 1;
            else pend_wait--;
        end
        imem_rvalid    = give | late_rvalid;
        imem_rdata     = give ? mem_word(pend_pc) : 32'hDEAD_BEEF;
        late_rvalid    = 0;
        redirect_valid = tb_redirect;
        redirect_pc    = tb_redirect_pc;
        instr_ready    = tb_ready;
        imem_ready     = tb_mem_ready;
        if (tb_redirect) begin
            sb.delete();
            exp_pc = {tb_redirect_pc[31:2], 2'b00};
            if (pend && !give) pend_drop = 1;
        end
        if (give) begin
            if (!pend_drop && !tb_redirect) begin
                if (sb.size() == 0) begin
                    lat_armed = 1;
                    lat_pc    = pend_pc;
                    lat_due   = cyc + LAT;
                end
                sb.push_back('{pc: pend_pc, word: mem_word(pend_pc)});
            end
            pend      = 0;
            pend_drop = 0;
        end
        tb_redirect = 0;

        @(negedge clk);
        if (lat_armed && cyc == lat_due) begin
            lat_armed = 0;
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== lat_pc) begin
                errors++;
                $display("FAIL latency: instr_valid=%b instr_pc=%h, required 1 / %h", instr_valid, instr_pc, lat_pc);
            end
        end
        if (instr_valid === 1'b1 && instr_ready && !redirect_valid) begin
            pop_log.push_back(instr_pc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_instr: got pc=%h word=%h, required no instruction", instr_pc, instr);
            end else begin
                e = sb.pop_front();
                if (instr_pc !== e.pc || instr !== e.word) begin
                    errors++;
                    $display("FAIL instr_data: got pc=%h word=%h, required pc=%h word=%h", instr_pc, instr, e.pc, e.word);
                end
                checks++;
                if (op !== e.word[27:26] || funct !== e.word[25:20] || rd !== e.word[15:12] ||
                    instr_7 !== e.word[7] || instr_4 !== e.word[4]) begin
                    errors++;
                    $display("FAIL decode_fields: got op=%h funct=%h rd=%h b7=%b b4=%b for word %h",
                             op, funct, rd, instr_7, instr_4, e.word);
                end
            end
        end else if (instr_valid !== 1'b1) begin
            checks++;
            if (instr !== 32'h0 || instr_pc !== 32'h0) begin
                errors++;
                $display("FAIL idle_outputs: instr=%h instr_pc=%h, required 0 / 0", instr, instr_pc);
            end
        end
        if (imem_req === 1'b1 && imem_ready) begin
            acc_log.push_back(imem_addr);
            checks++;
            if (imem_addr !== exp_pc || pend) begin
                errors++;
                $display("FAIL fetch_addr: got %h (in flight=%0d), required %h with nothing in flight", imem_addr, pend, exp_pc);
            end
            pend      = 1;
            pend_pc   = exp_pc;
            pend_wait = mem_lat;
            pend_drop = 0;
            exp_pc    = exp_pc + 32'd4;
        end
    endtask

    task automatic apply_reset();
        reset          = 1'b0;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        tb_redirect    = 0;
        tb_ready       = 1;
        tb_mem_ready   = 1;
        late_rvalid    = 0;
        pend           = 0;
        pend_drop      = 0;
        mem_lat        = 1;
        lat_armed      = 0;
        exp_pc         = RESET_PC;
        sb.delete();
        acc_log.delete();
        pop_log.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until_acc(input int n);
        int budget;
        budget = 40;
        while (acc_log.size() < n && budget > 0) begin
            cycle();
            budget--;
        end
        checks++;
        if (acc_log.size() < n) begin
            errors++;
            $display("FAIL acc_timeout: got %0d fetches, required %0d", acc_log.size(), n);
        end
    endtask

    task automatic run_until_pop(input int n);
        int budget;
        budget = 40;
        while (pop_log.size() < n && budget > 0) begin
            cycle();
            budget--;
        end
        checks++;
        if (pop_log.size() < n) begin
            errors++;
            $display("FAIL pop_timeout: got %0d instructions, required %0d", pop_log.size(), n);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_req: imem_req=%b imem_addr=%h, required 0 / %h", imem_req, imem_addr, RESET_PC);
        end
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_instr: valid=%b instr=%h pc=%h, required 0 / 0 / 0", instr_valid, instr, instr_pc);
        end
        reset = 1'b1;
        cycle();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_req: imem_req=%b imem_addr=%h, required 1 / %h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_fetch_sequence();
        int p0;
        run_until_pop(3);
        if (pop_log.size() >= 3) begin
            checks++;
            if (acc_log[0] !== 32'h0 || acc_log[1] !== 32'h4 || acc_log[2] !== 32'h8) begin
                errors++;
                $display("FAIL seq_addr: got %h %h %h, required 0 4 8", acc_log[0], acc_log[1], acc_log[2]);
            end
            checks++;
            if (pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4 || pop_log[2] !== 32'h8) begin
                errors++;
                $display("FAIL seq_pc: got %h %h %h, required 0 4 8", pop_log[0], pop_log[1], pop_log[2]);
            end
        end
        p0 = pop_log.size();
        repeat (20) cycle();
        checks++;
        if (pop_log.size() - p0 != 10) begin
            errors++;
            $display("FAIL throughput: got %0d instructions in 20 cycles, required 10", pop_log.size() - p0);
        end
    endtask

    task automatic test_latency();
        apply_reset();
        reset = 1'b1;
        cycle();   // request for RESET_PC accepted
        cycle();   // response returns
`ifdef FETCH_BYPASS_EN
        checks++;
        if (instr_valid !== 1'b1 || instr !== mem_word(RESET_PC) || instr_pc !== RESET_PC) begin
            errors++;
            $display("FAIL bypass_same_cycle: valid=%b instr=%h pc=%h, required 1 / %h / %h",
                     instr_valid, instr, instr_pc, mem_word(RESET_PC), RESET_PC);
        end
        cycle();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL bypass_not_pushed: instr_valid=%b, required 0", instr_valid);
        end
`else
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: instr_valid=%b in rvalid cycle, required 0", instr_valid);
        end
        cycle();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== RESET_PC) begin
            errors++;
            $display("FAIL latency_next: valid=%b pc=%h, required 1 / %h", instr_valid, instr_pc, RESET_PC);
        end
`endif
    endtask

    task automatic test_backpressure();
        apply_reset();
        reset    = 1'b1;
        tb_ready = 0;
        repeat (8) cycle();
        repeat (4) begin
            cycle();
            checks++;
            if (imem_req !== 1'b0) begin
                errors++;
                $display("FAIL full_no_req: imem_req=%b with FIFO full, required 0", imem_req);
            end
        end
        checks++;
        if (acc_log.size() != DEPTH || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL full_state: fetches=%0d valid=%b pc=%h, required %0d / 1 / 0",
                     acc_log.size(), instr_valid, instr_pc, DEPTH);
        end
        tb_ready = 1;
        run_until_acc(DEPTH + 1);
        if (acc_log.size() > DEPTH) begin
            checks++;
            if (acc_log[DEPTH] !== 32'h8) begin
                errors++;
                $display("FAIL resume_addr: got %h, required 00000008", acc_log[DEPTH]);
            end
        end
        run_until_pop(3);
    endtask

    task automatic test_redirect_wait();
        int n;
        apply_reset();
        reset   = 1'b1;
        mem_lat = 3;
        run_until_acc(2);
        n = pop_log.size();
        tb_redirect    = 1;
        tb_redirect_pc = 32'h0000_0100;
        cycle();
        cycle();
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_wait: imem_req=%b instr_valid=%b, required 0 / 0", imem_req, instr_valid);
        end
        run_until_pop(n + 1);
        if (pop_log.size() > n) begin
            checks++;
            if (pop_log[n] !== 32'h0000_0100) begin
                errors++;
                $display("FAIL redirect_pc: got %h, required 00000100", pop_log[n]);
            end
        end
        mem_lat = 1;
    endtask

    task automatic test_redirect_idle_pop();
        int n;
        apply_reset();
        reset    = 1'b1;
        tb_ready = 0;
        repeat (8) cycle();
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_redirect_valid: instr_valid=%b, required 1", instr_valid);
        end
        n = pop_log.size();
        tb_ready       = 1;
        tb_redirect    = 1;
        tb_redirect_pc = 32'h0000_0203;
        cycle();
        tb_mem_ready = 0;
        cycle();
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin
            errors++;
            $display("FAIL redirect_idle: valid=%b req=%b addr=%h, required 0 / 1 / 00000200",
                     instr_valid, imem_req, imem_addr);
        end
        tb_mem_ready = 1;
        run_until_pop(n + 1);
        if (pop_log.size() > n) begin
            checks++;
            if (pop_log[n] !== 32'h0000_0200) begin
                errors++;
                $display("FAIL redirect_idle_pc: got %h, required 00000200", pop_log[n]);
            end
        end
    endtask

    task automatic test_wrap();
        int n;
        tb_redirect    = 1;
        tb_redirect_pc = 32'hFFFF_FFFC;
        cycle();
        n = acc_log.size();
        run_until_acc(n + 2);
        if (acc_log.size() >= n + 2) begin
            checks++;
            if (acc_log[n] !== 32'hFFFF_FFFC || acc_log[n+1] !== 32'h0000_0000) begin
                errors++;
                $display("FAIL wrap: got %h then %h, required FFFFFFFC then 00000000", acc_log[n], acc_log[n+1]);
            end
        end
        repeat (4) cycle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        reset   = 1'b1;
        mem_lat = 3;
        run_until_acc(1);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL mid_reset: req=%b valid=%b addr=%h, required 0 / 0 / %h",
                     imem_req, instr_valid, imem_addr, RESET_PC);
        end
        apply_reset();
        reset        = 1'b1;
        late_rvalid  = 1;
        tb_mem_ready = 0;
        cycle();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL late_rvalid: instr_valid=%b, required 0", instr_valid);
        end
        cycle();
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL late_rvalid_after: valid=%b req=%b addr=%h, required 0 / 1 / %h",
                     instr_valid, imem_req, imem_addr, RESET_PC);
        end
        tb_mem_ready = 1;
        run_until_pop(1);
        if (pop_log.size() > 0) begin
            checks++;
            if (pop_log[0] !== RESET_PC) begin
                errors++;
                $display("FAIL restart_pc: got %h, required %h", pop_log[0], RESET_PC);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fetch_sequence();
        test_latency();
        test_backpressure();
        test_redirect_wait();
        test_redirect_idle_pop();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage ahead of the control unit. Owns the program counter, issues word fetches to instruction memory with at most one request in flight, and buffers returned words in a small prefetch FIFO. Presents each instruction, its PC, and the pre-sliced decode fields (op, funct, rd, bit 7, bit 4) to the decoder through a valid/ready handshake. Flushes on a branch/PC-write redirect.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2: prefetch entries; power of two, ≥2.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  word-aligned fetch address.
- imem_ready  in  1  request accepted when imem_req & imem_ready.
- imem_rvalid  in  1  read data valid; exactly one per accepted request, ≥1 cycle after acceptance.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  PC redirect (branch taken or PC written).
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0).
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decoder consumes head when instr_valid & instr_ready.
- instr  out  32  head instruction word.
- instr_pc  out  32  address of head instruction.
- op  out  2  instr[27:26].
- funct  out  6  instr[25:20].
- rd  out  4  instr[15:12].
- instr_7  out  1  instr[7].
- instr_4  out  1  instr[4].

## Operation
- Registers: fetch_pc, FIFO (entries of {pc, word}), count, 3-state FSM.
- FSM states: IDLE (nothing in flight), WAIT (one request in flight, response kept), DROP (one in flight, response discarded).
- IDLE: imem_req = 1 when count < FIFO_DEPTH and redirect_valid = 0; imem_addr = fetch_pc. On acceptance: fetch_pc += 4 (wraps modulo 2^32), go WAIT.
- WAIT: imem_req = 0. On imem_rvalid: push {pc of request, imem_rdata}, go IDLE.
- DROP: imem_req = 0. On imem_rvalid: discard data, go IDLE.
- Redirect (highest priority): FIFO flushed (count = 0), fetch_pc = {redirect_pc[31:2], 2'b00}; WAIT→DROP, DROP stays DROP, IDLE stays IDLE; no request issued and no push in that cycle; any same-cycle pop is ignored.
- Push and pop in the same cycle: count unchanged. Push never occurs when full (guaranteed by issue condition, since at most one request is in flight and issue requires space).
- imem_req may drop without acceptance only in a redirect cycle; otherwise req and addr are held until accepted.
- instr, instr_pc = 0 when instr_valid = 0; decode field outputs are slices of instr.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, instr_valid 0, instr 0, instr_pc 0; fetch_pc RESET_PC, count 0, FSM IDLE.
- First imem_req asserted in the first cycle after reset deasserts.
- Latency, memory rvalid in cycle N: instr_valid in cycle N+1 (without bypass).
- Steady throughput with 1-cycle memory: one instruction per 2 cycles (single outstanding).
- Reset asserted mid-transaction: state returns to reset values immediately; a late imem_rvalid arriving in IDLE after reset is ignored.
- Redirect in cycle N: first new request in cycle N+1 if IDLE, else in the cycle after the dropped response returns.

## Configuration
- FETCH_BYPASS_EN defined: when count = 0 and imem_rvalid arrives in WAIT with no redirect, the word appears on instr/instr_pc/instr_valid combinationally in the same cycle; if instr_ready = 1 it is consumed and not pushed, otherwise it is pushed. Latency becomes 0 cycles.
- Not defined: all returned words go through the FIFO; latency 1 cycle.

## Structure
- Package fetch_pkg: fetch_entry_t struct {pc[31:0], word[31:0]}, fetch_state_t enum {IDLE, WAIT, DROP}, instruction field bit-position constants.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, parameterised depth, push/pop/flush, count output, async active-low reset.

## Test plan
- Reset then 1-cycle memory, instr_ready = 1: addresses 0x0, 0x4, 0x8 issued; instr_pc sequence 0x0, 0x4, 0x8; each instr_valid one cycle after its rvalid.
- instr_ready = 0: exactly FIFO_DEPTH words buffered, imem_req stays 0; raising instr_ready resumes fetch at 0x8.
- Redirect to 0x100 while in WAIT: in-flight response (0x4) dropped, FIFO empty, next instr_pc is 0x100.
- Redirect to 0x203 in IDLE with simultaneous pop: count 0, next imem_addr 0x200.
- fetch_pc = 0xFFFF_FFFC: next fetch wraps to 0x0000_0000.
- FETCH_BYPASS_EN defined, empty FIFO, instr_ready = 1: instr_valid and instr equal imem_rdata in the rvalid cycle; count stays 0.
